// File: rtl/pbkdf2_ctrl.sv
// rtl/pbkdf2_ctrl.sv - PBKDF2-HMAC-SHA256 first-block (T1) iteration controller driving a shared HMAC core
// Optional status outputs busy_o / iter_done_o are built only when PBKDF2_STATUS_EN is defined.
module pbkdf2_ctrl #(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [511:0]      pw_i,
    input  logic [511:0]      salt_i,
    input  logic [5:0]        salt_len_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic              v_i,
    output logic              r_o,
    output logic [255:0]      dk_o,
    output logic              v_o,
    input  logic              r_i,
    output logic [511:0]      hmac_key_o,
    output logic [511:0]      hmac_msg_o,
    output logic [5:0]        hmac_len_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    input  logic [255:0]      hmac_prf_i,
    input  logic              hmac_v_i,
    output logic              hmac_r_o
`ifdef PBKDF2_STATUS_EN
    ,
    output logic              busy_o,
    output logic [ITER_W-1:0] iter_done_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [5:0]   MAX_SALT = 6'd51;
    localparam logic [511:0] ONES     = '1;
    localparam logic [511:0] CTR_BLK  = {32'h0000_0001, 480'b0};

    state_t              state_q;
    state_t              state_d;
    logic [511:0]        pw_q;
    logic [511:0]        msg0_q;
    logic [5:0]          len0_q;
    logic [ITER_W-1:0]   c_q;
    logic [ITER_W-1:0]   n_q;
    logic [255:0]        u_q;
    logic [255:0]        t_q;

    logic [5:0]          salt_len_c;
    logic [8:0]          salt_bits_c;
    logic [511:0]        msg0_c;
    logic [ITER_W-1:0]   iter_c;
    logic [ITER_W-1:0]   n_inc;
    logic                job_go;
    logic                prf_go;

    // The first-round message (clamped salt followed by INT(1)) is built once at capture time.
    assign salt_len_c  = (salt_len_i > MAX_SALT) ? MAX_SALT : salt_len_i;
    assign salt_bits_c = {salt_len_c, 3'b000};
    assign msg0_c      = (salt_i & ~(ONES >> salt_bits_c)) | (CTR_BLK >> salt_bits_c);
    assign iter_c      = (iter_i == '0) ? ITER_W'(1) : iter_i;
    assign n_inc       = n_q + ITER_W'(1);

    assign job_go = r_o && v_i;
    assign prf_go = hmac_r_o && hmac_v_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_o      = 1'b0;
        hmac_v_o = 1'b0;
        hmac_r_o = 1'b0;
        v_o      = 1'b0;
        case (state_q)
            IDLE: begin
                r_o = !rst_i;
                if (v_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                hmac_v_o = 1'b1;
                if (hmac_r_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                hmac_r_o = 1'b1;
                if (hmac_v_i) begin
                    state_d = (n_inc == c_q) ? DONE : ISSUE;
                end
            end
            DONE: begin
                v_o = 1'b1;
                if (r_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pw_q   <= '0;
            msg0_q <= '0;
            len0_q <= '0;
            c_q    <= '0;
            n_q    <= '0;
            u_q    <= '0;
            t_q    <= '0;
        end else begin
            if (job_go) begin
                pw_q   <= pw_i;
                msg0_q <= msg0_c;
                len0_q <= salt_len_c + 6'd4;
                c_q    <= iter_c;
                n_q    <= '0;
            end
            if (prf_go) begin
                u_q <= hmac_prf_i;
                t_q <= (n_q == '0) ? hmac_prf_i : (t_q ^ hmac_prf_i);
                n_q <= n_inc;
            end
        end
    end

    // Request data comes straight from registers, so it cannot move while the core stalls.
    assign hmac_key_o = pw_q;
    assign hmac_msg_o = (n_q == '0) ? msg0_q : {u_q, 256'b0};
    assign hmac_len_o = (n_q == '0) ? len0_q : 6'd32;
    assign dk_o       = t_q;

`ifdef PBKDF2_STATUS_EN
    assign busy_o      = (state_q != IDLE);
    assign iter_done_o = n_q;
`endif

endmodule

// File: tb/tb_pbkdf2_ctrl.sv
// tb/tb_pbkdf2_ctrl.sv - self-checking bench for pbkdf2_ctrl with a behavioural HMAC-SHA256 core
module tb_pbkdf2_ctrl;

    localparam int ITER_W = 32;

    localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] PW     = {"password", 448'b0};
    localparam logic [511:0] SALT   = {"salt", 480'b0};
    localparam logic [255:0] DK1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

    typedef struct {
        logic [511:0] pw;
        logic [511:0] salt;
        logic [5:0]   len;
        logic [31:0]  iter;
        logic [255:0] dk;
        bit           use_model;
        int           lat;
        bit           stall;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [511:0]      pw_i;
    logic [511:0]      salt_i;
    logic [5:0]        salt_len_i;
    logic [ITER_W-1:0] iter_i;
    logic              v_i;
    logic              r_o;
    logic [255:0]      dk_o;
    logic              v_o;
    logic              r_i;
    logic [511:0]      hmac_key_o;
    logic [511:0]      hmac_msg_o;
    logic [5:0]        hmac_len_o;
    logic              hmac_v_o;
    logic              hmac_r_i;
    logic [255:0]      hmac_prf_i;
    logic              hmac_v_i;
    logic              hmac_r_o;
`ifdef PBKDF2_STATUS_EN
    logic              busy_o;
    logic [ITER_W-1:0] iter_done_o;
`endif

    int checks = 0;
    int errors = 0;

    // Expectations shared with the core model for the job in flight.
    logic [511:0] exp_pw;
    logic [511:0] exp_msg0;
    logic [5:0]   exp_len0;
    int           job_reqs;
    int           core_lat;
    bit           core_stall;
    bit           inject;
    logic [255:0] last_prf;
    logic [255:0] sb[$];

    always #5 clk = ~clk;

    pbkdf2_ctrl #(.ITER_W(ITER_W)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .pw_i(pw_i),
        .salt_i(salt_i),
        .salt_len_i(salt_len_i),
        .iter_i(iter_i),
        .v_i(v_i),
        .r_o(r_o),
        .dk_o(dk_o),
        .v_o(v_o),
        .r_i(r_i),
        .hmac_key_o(hmac_key_o),
        .hmac_msg_o(hmac_msg_o),
        .hmac_len_o(hmac_len_o),
        .hmac_v_o(hmac_v_o),
        .hmac_r_i(hmac_r_i),
        .hmac_prf_i(hmac_prf_i),
        .hmac_v_i(hmac_v_i),
        .hmac_r_o(hmac_r_o)
`ifdef PBKDF2_STATUS_EN
        ,
        .busy_o(busy_o),
        .iter_done_o(iter_done_o)
`endif
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // HMAC-SHA256 for keys up to 64 bytes and messages up to 55 bytes.
    function automatic logic [255:0] hmac(input logic [511:0] key, input logic [511:0] msg, input int len);
        logic [511:0] blk;
        logic [255:0] ih;
        blk = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < len) blk[511-8*i -: 8] = msg[511-8*i -: 8];
            else if (i == len) blk[511-8*i -: 8] = 8'h80;
        end
        blk[63:0] = 64'((64 + len) * 8);
        ih  = sha_blk(sha_blk(H0, key ^ {64{8'h36}}), blk);
        blk = {ih, 8'h80, 184'b0, 64'd768};
        return sha_blk(sha_blk(H0, key ^ {64{8'h5c}}), blk);
    endfunction

    function automatic logic [511:0] first_msg(input logic [511:0] salt, input int L);
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < L) m[511-8*i -: 8] = salt[511-8*i -: 8];
            else if (i == L + 3) m[511-8*i -: 8] = 8'h01;
        end
        return m;
    endfunction

    function automatic logic [255:0] pbkdf2_ref(input logic [511:0] pw, input logic [511:0] salt,
                                                input int L, input int c);
        logic [255:0] u, t;
        u = hmac(pw, first_msg(salt, L), L + 4);
        t = u;
        for (int i = 1; i < c; i++) begin
            u = hmac(pw, {u, 256'b0}, 32);
            t = t ^ u;
        end
        return t;
    endfunction

    function automatic vec_t mk(input logic [511:0] pw, input logic [511:0] salt, input logic [5:0] len,
                                input logic [31:0] iter, input logic [255:0] dk, input bit use_model,
                                input int lat, input bit stall);
        vec_t v;
        v.pw = pw; v.salt = salt; v.len = len; v.iter = iter; v.dk = dk;
        v.use_model = use_model; v.lat = lat; v.stall = stall;
        return v;
    endfunction

    // Behavioural HMAC core: checks each accepted request and answers after core_lat cycles.
    initial begin
        bit           busy;
        bit           pend;
        int           cnt;
        logic [255:0] resp;
        logic [511:0] s_key, s_msg;
        logic [5:0]   s_len;
        busy = 0; pend = 0; cnt = 0; resp = '0;
        s_key = '0; s_msg = '0; s_len = '0;
        hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_i) begin
                busy = 0; pend = 0; hmac_v_i = 1'b0; hmac_r_i = 1'b0;
            end else begin
                if (pend) begin
                    check("hmac_v_hold", 512'(hmac_v_o), 512'(1));
                    check("hmac_key_hold", hmac_key_o, s_key);
                    check("hmac_msg_hold", hmac_msg_o, s_msg);
                    check("hmac_len_hold", 512'(hmac_len_o), 512'(s_len));
                end
                hmac_v_i = 1'b0;
                if (inject) begin
                    hmac_v_i = 1'b1;
                    hmac_prf_i = {8{32'hbad0_0bad}};
                    inject = 0;
                end else if (busy) begin
                    if (cnt > 0) begin
                        cnt--;
                    end else if (!core_stall || $urandom_range(1, 0) == 1) begin
                        hmac_v_i = 1'b1;
                        hmac_prf_i = resp;
                        if (hmac_r_o) begin
                            busy = 0;
                            last_prf = resp;
                        end
                    end
                end
                hmac_r_i = !busy && (!core_stall || $urandom_range(1, 0) == 1);
                pend = hmac_v_o && !hmac_r_i;
                s_key = hmac_key_o; s_msg = hmac_msg_o; s_len = hmac_len_o;
                if (hmac_v_o && hmac_r_i) begin
                    check("req_key", hmac_key_o, exp_pw);
                    if (job_reqs == 0) begin
                        check("req_len_first", 512'(hmac_len_o), 512'(exp_len0));
                        check("req_msg_first", hmac_msg_o, exp_msg0);
                    end else begin
                        check("req_len_next", 512'(hmac_len_o), 512'(32));
                        check("req_msg_next", hmac_msg_o, {last_prf, 256'b0});
                    end
                    resp = hmac(hmac_key_o, hmac_msg_o, int'(hmac_len_o));
                    busy = 1;
                    cnt = core_lat;
                    job_reqs++;
                end
            end
        end
    end

    task automatic set_job(input vec_t v);
        int L;
        L = (v.len > 6'd51) ? 51 : int'(v.len);
        exp_pw = v.pw;
        exp_msg0 = first_msg(v.salt, L);
        exp_len0 = 6'(L + 4);
        job_reqs = 0;
        core_lat = v.lat;
        core_stall = v.stall;
        pw_i = v.pw; salt_i = v.salt; salt_len_i = v.len; iter_i = v.iter;
    endtask

    task automatic run_job(input vec_t v);
        int   iters, t, lat, L;
        bit   done;
        logic [255:0] held;
        L = (v.len > 6'd51) ? 51 : int'(v.len);
        iters = (v.iter == 0) ? 1 : int'(v.iter);
        set_job(v);
        sb.push_back(v.use_model ? pbkdf2_ref(v.pw, v.salt, L, iters) : v.dk);
        v_i = 1'b1;
        t = 0;
        while (!r_o && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("job_accept", 512'(r_o), 512'(1));
        @(posedge clk); #1;
        v_i = 1'b0;
        lat = 0;
        while (!v_o && lat < 60000) begin
            if (v.stall) begin
                v_i = 1'($urandom_range(1, 0));
                pw_i = {16{$urandom}};
                salt_i = {16{$urandom}};
                iter_i = $urandom;
            end
            @(posedge clk); #1; lat++;
        end
        v_i = 1'b0;
        check("done_reached", 512'(v_o), 512'(1));
        if (!v.stall) check("latency", 512'(lat), 512'(iters * (2 + v.lat)));
        t = 0; done = 0;
        while (!done && t < 200) begin
            r_i = v.stall ? 1'($urandom_range(1, 0)) : 1'b1;
            if (r_i) begin
                if (sb.size() == 0) check("sb_underflow", 512'(1), 512'(0));
                else check("dk", 512'(dk_o), 512'(sb.pop_front()));
                done = 1;
            end
            held = dk_o;
            @(posedge clk); #1;
            r_i = 1'b0;
            t++;
            if (!done) check("dk_hold", 512'({v_o, dk_o}), 512'({1'b1, held}));
        end
        check("result_taken", 512'(done), 512'(1));
        check("core_xfers", 512'(job_reqs), 512'(iters));
        check("idle_after", 512'(r_o), 512'(1));
    endtask

    initial begin
        vec_t vecs [7];
        vec_t rst_job;
        int   t;
        vecs[0] = mk(PW, SALT, 6'd4, 32'd1, DK1, 0, 0, 0);
        vecs[1] = mk(PW, SALT, 6'd4, 32'd2, DK2, 0, 1, 0);
        vecs[2] = mk(PW, SALT, 6'd4, 32'd0, DK1, 0, 2, 0);
        vecs[3] = mk(PW, {16{32'ha5c3_0f17}}, 6'd60, 32'd2, '0, 1, 1, 0);
        vecs[4] = mk({"Secret#Key", 432'b0}, {"NaCl-and-more-bytes!", {11{32'hdead_beef}}}, 6'd20, 32'd3, '0, 1, 0, 1);
        vecs[5] = mk(PW, SALT, 6'd4, 32'd2, DK2, 0, 0, 1);
        vecs[6] = mk(PW, SALT, 6'd4, 32'd4096, DK4096, 0, 0, 0);

        rst_i = 1'b1; v_i = 1'b0; r_i = 1'b0;
        pw_i = '0; salt_i = '0; salt_len_i = '0; iter_i = '0;
        exp_pw = '0; exp_msg0 = '0; exp_len0 = '0; job_reqs = 0;
        core_lat = 0; core_stall = 0; inject = 0; last_prf = '0;
        repeat (3) @(posedge clk);
        #1;
        check("r_o_in_reset", 512'(r_o), 512'(0));
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("rst_r_o", 512'(r_o), 512'(1));
        check("rst_v_o", 512'(v_o), 512'(0));
        check("rst_hmac_v_o", 512'(hmac_v_o), 512'(0));
        check("rst_hmac_r_o", 512'(hmac_r_o), 512'(0));
        check("rst_dk_o", 512'(dk_o), 512'(0));
`ifdef PBKDF2_STATUS_EN
        check("rst_busy", 512'(busy_o), 512'(0));
        check("rst_iter_done", 512'(iter_done_o), 512'(0));
`endif

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // Reset during WAIT of the third iteration of a ten-iteration job.
        rst_job = mk(PW, SALT, 6'd4, 32'd10, '0, 0, 1, 0);
        set_job(rst_job);
        v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        t = 0;
        while (!(hmac_r_o && job_reqs == 3) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("reach_wait_iter3", 512'(hmac_r_o && job_reqs == 3), 512'(1));
`ifdef PBKDF2_STATUS_EN
        check("busy_mid_job", 512'(busy_o), 512'(1));
        check("iter_done_mid", 512'(iter_done_o), 512'(2));
`endif
        rst_i = 1'b1;
        @(negedge clk);
        check("r_o_in_reset_mid", 512'(r_o), 512'(0));
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("mid_rst_r_o", 512'(r_o), 512'(1));
        check("mid_rst_v_o", 512'(v_o), 512'(0));
        check("mid_rst_hmac_v_o", 512'(hmac_v_o), 512'(0));
        check("mid_rst_hmac_r_o", 512'(hmac_r_o), 512'(0));
        check("mid_rst_dk_o", 512'(dk_o), 512'(0));
        @(posedge clk); #1;
        inject = 1;
        repeat (3) @(posedge clk);
        #1;
        check("stray_prf_v_o", 512'(v_o), 512'(0));
        check("stray_prf_r_o", 512'(r_o), 512'(1));
        check("stray_prf_dk_o", 512'(dk_o), 512'(0));
        run_job(vecs[0]);

        run_job(vecs[6]);

        check("sb_empty", 512'(sb.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pbkdf2_ctrl.md
PBKDF2_CTRL -- requirements
Module: pbkdf2_ctrl

Interface
- REQ-001 SHALL have parameter ITER_W, default 32, the width of the iteration count and status counter.
- REQ-002 SHALL have clk_i, input, 1: the single clock; all logic is on the rising edge.
- REQ-003 SHALL have rst_i, input, 1: reset, synchronous and active-high.
- REQ-004 SHALL have pw_i, input, 512: password, left-aligned, zero-filled on the right.
- REQ-005 SHALL have salt_i, input, 512: salt, left-aligned, zero-filled on the right.
- REQ-006 SHALL have salt_len_i, input, 6: salt length in bytes.
- REQ-007 SHALL have iter_i, input, ITER_W: PBKDF2 iteration count c.
- REQ-008 SHALL have v_i (input, 1) and r_o (output, 1): job request handshake.
- REQ-009 SHALL have dk_o, output, 256: derived key T1.
- REQ-010 SHALL have v_o (output, 1) and r_i (input, 1): result handshake.
- REQ-011 SHALL have hmac_key_o (output, 512), hmac_msg_o (output, 512) and hmac_len_o (output, 6): key, message and message length in bytes driven to the shared HMAC-SHA256 core.
- REQ-012 SHALL have hmac_v_o (output, 1) and hmac_r_i (input, 1): core request handshake.
- REQ-013 SHALL have hmac_prf_i (input, 256), hmac_v_i (input, 1) and hmac_r_o (output, 1): core response handshake.

Function
- REQ-014 A transfer SHALL occur only on a cycle where valid and ready are both high.
- REQ-015 States: IDLE, ISSUE, WAIT, DONE; no other state is reachable.
- REQ-016 IDLE: r_o=1; on v_i, capture pw_i, salt_i, salt_len_i and iter_i, clear counter n to 0, go to ISSUE.
- REQ-017 iter_i=0 SHALL be treated as 1.
- REQ-018 salt_len_i>51 SHALL be clamped to 51; salt bytes beyond the clamped length are zeroed.
- REQ-019 ISSUE: hmac_v_o=1 and hmac_key_o=captured password.
- REQ-020 ISSUE with n=0: hmac_msg_o = salt with 32'h00000001 placed at byte offset L, zero-filled; hmac_len_o=L+4, where L is the clamped length.
- REQ-021 ISSUE with n>0: hmac_msg_o={U,256'b0} and hmac_len_o=32.
- REQ-022 ISSUE: on hmac_r_i go to WAIT; hmac_v_o and all hmac_* data SHALL stay stable until accepted.
- REQ-023 WAIT: hmac_r_o=1; on hmac_v_i, U<=hmac_prf_i, T<=(n==0 ? hmac_prf_i : T^hmac_prf_i), n<=n+1.
- REQ-024 WAIT: after that update, go to DONE if n+1==c, else go to ISSUE.
- REQ-025 DONE: v_o=1 and dk_o=T, held stable; on r_i go to IDLE.
- REQ-026 r_o, hmac_v_o, hmac_r_o and v_o SHALL be mutually exclusive, one per state as above.
- REQ-027 Overhead per iteration SHALL be exactly 2 cycles plus the core latency.
- REQ-028 Request-to-DONE latency for c iterations SHALL be c*(2+core latency) cycles.
- REQ-029 n SHALL be ITER_W wide with no wrap, since n+1==c terminates before overflow.
- REQ-030 v_i asserted outside IDLE SHALL be ignored and SHALL NOT corrupt captured state.

Reset
- REQ-031 On rst_i in any state, including mid-iteration, the next state SHALL be IDLE.
- REQ-032 Reset values: r_o=0 during the reset cycle, then 1 in IDLE; v_o=0, hmac_v_o=0, hmac_r_o=0; dk_o, T, U and n all 0.
- REQ-033 An hmac_v_i arriving after reset SHALL be ignored; the core shares rst_i.

Configuration
- REQ-034 With PBKDF2_STATUS_EN defined, the block SHALL add busy_o (output, 1), high in ISSUE, WAIT and DONE.
- REQ-035 With PBKDF2_STATUS_EN defined, the block SHALL add iter_done_o (output, ITER_W) equal to n, reset to 0.
- REQ-036 Without PBKDF2_STATUS_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
- REQ-037 pw="password", salt="salt", len=4, c=1 -> dk_o=120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b, with one core request of len 8.
- REQ-038 Same inputs, c=2 -> dk_o=ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43, with the second request hmac_len_o=32.
- REQ-039 Same inputs, c=4096 -> dk_o=c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a, with exactly 4096 core transfers.
- REQ-040 c=0 -> result identical to c=1; salt_len_i=60 -> hmac_len_o=55.
- REQ-041 Randomly stall hmac_r_i, hmac_v_i and r_i at 50% -> same dk_o, and hmac_* data stable while stalled.
- REQ-042 Assert rst_i in WAIT at iteration 3 of c=10 -> IDLE next cycle, v_o=0; a fresh c=1 job then yields the REQ-037 vector.
